btn_toggle_ctrl: RTL and testbench
==================================

BTN_TOGGLE_CTRL -- requirements
Module: btn_toggle_ctrl

Interface
REQ-001 Parameter DB_CYCLES, default 4, meaning: consecutive synchronized samples required to accept a press or a release; legal range 2..65535.
REQ-002 clk  input  1  sole clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 in  input  1  raw push-button level, active-high, asynchronous to clk, may bounce.
REQ-005 clr  input  1  synchronous clear of selection and toggle count; does not affect FSM state.
REQ-006 sel_out  output  1  current selection; toggles once per accepted press.
REQ-007 pulse  output  1  one-cycle strobe marking an accepted press.
REQ-008 toggle_cnt  output  4  number of accepted presses, modulo 16.
REQ-009 busy  output  1  high whenever FSM state is not IDLE.

Function
REQ-010 The block SHALL pass in through a two-flop synchronizer (sync1, in_s); the FSM and counter SHALL use in_s only.
REQ-011 The block SHALL implement four states: IDLE, DB_PRESS, HELD, DB_RELEASE; encoding is free.
REQ-012 The debounce counter SHALL be 16 bits and SHALL be cleared on every entry to DB_PRESS or DB_RELEASE.
REQ-013 IDLE: in_s=1 -> DB_PRESS, cnt<=0; otherwise stay.
REQ-014 DB_PRESS: in_s=0 -> IDLE (bounce rejected, no toggle); in_s=1 and cnt<DB_CYCLES-1 -> cnt<=cnt+1; in_s=1 and cnt==DB_CYCLES-1 -> HELD (accept).
REQ-015 HELD: in_s=0 -> DB_RELEASE, cnt<=0; otherwise stay; a held button SHALL produce no further toggles.
REQ-016 DB_RELEASE: in_s=1 -> HELD (bounce, no toggle); in_s=0 and cnt<DB_CYCLES-1 -> cnt<=cnt+1; in_s=0 and cnt==DB_CYCLES-1 -> IDLE.
REQ-017 On the DB_PRESS->HELD edge the block SHALL register pulse<=1, sel_out<=~sel_out, toggle_cnt<=toggle_cnt+1; pulse SHALL be 0 on every other cycle.
REQ-018 Latency: with in rising and stable before posedge 0, sel_out/pulse SHALL update at posedge 2+DB_CYCLES (posedge 6 for DB_CYCLES=4).
REQ-019 Release latency: with in falling and stable before posedge r, the FSM SHALL return to IDLE at posedge r+2+DB_CYCLES.
REQ-020 toggle_cnt SHALL wrap 15 -> 0 with no flag.
REQ-021 clr=1 SHALL set sel_out<=0 and toggle_cnt<=0 on the next edge; when clr coincides with an accept, clr SHALL win (sel_out=0, toggle_cnt=0) and pulse SHALL still assert.
REQ-022 All outputs SHALL be registered; no combinational path from in or clr to any output.
REQ-023 busy SHALL be asserted in DB_PRESS, HELD, DB_RELEASE and deasserted in IDLE.

Reset
REQ-024 rst=1 at a clock edge SHALL force state=IDLE, cnt=0, sync1=0, in_s=0, sel_out=0, pulse=0, toggle_cnt=0, busy=0.
REQ-025 rst SHALL take priority over clr and over any in activity, including mid-debounce or in HELD.
REQ-026 After rst deasserts with in held high, the block SHALL treat it as a new press and accept it at posedge 2+DB_CYCLES after the first non-reset edge.

Verification (DB_CYCLES=4)
REQ-027 Clean press: in 0->1 held 10 cycles -> pulse high for exactly one cycle at posedge 6, sel_out 0->1, toggle_cnt=1, busy high from posedge 2.
REQ-028 Bounce reject: in high 3 cycles then low -> no pulse, sel_out=0, toggle_cnt=0, FSM back in IDLE, busy low.
REQ-029 Release bounce: press accepted, then in low 2 cycles, high 1 cycle, low 8 cycles -> no second pulse, IDLE reached 6 edges after final fall, sel_out unchanged.
REQ-030 Wrap: 17 clean press/release pairs -> toggle_cnt=1, sel_out=1, 17 pulses total.
REQ-031 clr collision: assert clr on the cycle before the accepting edge -> pulse=1, sel_out=0, toggle_cnt=0 after that edge.
REQ-032 Reset mid-operation: rst=1 for one edge while in HELD with sel_out=1 -> all outputs 0 next cycle; in still high -> new accept and sel_out=1 at 2+DB_CYCLES edges after rst release.

Source files
------------

// File: rtl/btn_toggle_ctrl.sv
// btn_toggle_ctrl
//    Debounced push-button toggle. The raw button level is synchronized,
//    then debounced by a small FSM. Each accepted press flips the selection,
//    bumps a 4-bit press counter and emits a one-cycle strobe.
//
// Ports
//    clk         sole clock, rising edge
//    rst         synchronous active-high reset
//    in          raw button level, active-high, asynchronous, may bounce
//    clr         synchronous clear of sel_out and toggle_cnt
//    sel_out     current selection, flips once per accepted press
//    pulse       one-cycle strobe on each accepted press
//    toggle_cnt  accepted presses, modulo 16
//    busy        high whenever the FSM is not idle
//
// State table
//    state          | meaning
//    ---------------+------------------------------------------------------
//    ST_IDLE        | button released and stable, waiting for a press
//    ST_DB_PRESS    | button seen high, counting stable high samples
//    ST_HELD        | press accepted, waiting for the button to drop
//    ST_DB_RELEASE  | button seen low, counting stable low samples

module btn_toggle_ctrl #(
   parameter int unsigned DB_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in,
   input  logic       clr,
   output logic       sel_out,
   output logic       pulse,
   output logic [3:0] toggle_cnt,
   output logic       busy
);

   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_DB_PRESS   = 2'd1,
      ST_HELD       = 2'd2,
      ST_DB_RELEASE = 2'd3
   } state_t;

   // Terminal count: the debounce counter starts at 0 on entry, so the
   // sample that finds it at DB_CYCLES-1 is the DB_CYCLES-th stable one.
   localparam logic [15:0] C_CNT_LAST = 16'(DB_CYCLES - 1);

   logic        r_sync1;
   logic        r_in_s;
   state_t      r_state;
   state_t      w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic        w_accept;
   logic        r_sel;
   logic        r_pulse;
   logic [3:0]  r_toggle_cnt;
   logic        r_busy;

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_accept    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (r_in_s) begin
               w_state_nxt = ST_DB_PRESS;
               w_cnt_nxt   = 16'd0;
            end
         end
         ST_DB_PRESS: begin
            if (!r_in_s) begin
               w_state_nxt = ST_IDLE;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = ST_HELD;
               w_accept    = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         ST_HELD: begin
            if (!r_in_s) begin
               w_state_nxt = ST_DB_RELEASE;
               w_cnt_nxt   = 16'd0;
            end
         end
         ST_DB_RELEASE: begin
            if (r_in_s) begin
               // Bounce while releasing: still held, no new toggle.
               w_state_nxt = ST_HELD;
            end else if (r_cnt == C_CNT_LAST) begin
               w_state_nxt = ST_IDLE;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync1      <= 1'b0;
         r_in_s       <= 1'b0;
         r_state      <= ST_IDLE;
         r_cnt        <= 16'd0;
         r_sel        <= 1'b0;
         r_pulse      <= 1'b0;
         r_toggle_cnt <= 4'd0;
         r_busy       <= 1'b0;
      end else begin
         r_sync1 <= in;
         r_in_s  <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_pulse <= w_accept;
         // busy tracks the state being entered so it lines up with r_state.
         r_busy  <= (w_state_nxt != ST_IDLE);
         // clr beats a coincident accept; the strobe above still fires.
         if (clr) begin
            r_sel        <= 1'b0;
            r_toggle_cnt <= 4'd0;
         end else if (w_accept) begin
            r_sel        <= ~r_sel;
            r_toggle_cnt <= r_toggle_cnt + 4'd1;
         end
      end
   end

   assign sel_out    = r_sel;
   assign pulse      = r_pulse;
   assign toggle_cnt = r_toggle_cnt;
   assign busy       = r_busy;

endmodule

// File: tb/tb_btn_toggle_ctrl.sv
module tb_btn_toggle_ctrl;

   localparam int unsigned DB = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       in;
   logic       clr;
   logic       sel_out;
   logic       pulse;
   logic [3:0] toggle_cnt;
   logic       busy;

   int n_chk  = 0;
   int n_pass = 0;
   int pulse_cnt = 0;
   int p0;

   btn_toggle_ctrl #(.DB_CYCLES(DB)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .in         (in),
      .clr        (clr),
      .sel_out    (sel_out),
      .pulse      (pulse),
      .toggle_cnt (toggle_cnt),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Count strobes shortly after each edge, well before the negedge reads.
   always @(posedge clk) begin
      #2;
      if (pulse === 1'b1) pulse_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
   endtask

   // Advance n rising edges and park on the following falling edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(2);
      rst = 1'b0;
   endtask

   // Clean press held 8 edges (accept at edge 6), then release fully idle.
   task automatic press_release();
      in = 1'b1;
      step(8);
      in = 1'b0;
      step(8);
   endtask

   initial begin
      rst = 1'b1; in = 1'b0; clr = 1'b0;
      @(negedge clk);
      do_reset();
      chk("rst_sel",   sel_out,    0);
      chk("rst_pulse", pulse,      0);
      chk("rst_cnt",   toggle_cnt, 0);
      chk("rst_busy",  busy,       0);

      // Clean press: busy from edge 2, strobe at edge 6 only.
      p0 = pulse_cnt;
      in = 1'b1;
      step(2);
      chk("press_busy_e1", busy, 0);
      step(1);
      chk("press_busy_e2", busy, 1);
      step(3);
      chk("press_pulse_e5", pulse, 0);
      chk("press_sel_e5",   sel_out, 0);
      step(1);
      chk("press_pulse_e6", pulse, 1);
      chk("press_sel_e6",   sel_out, 1);
      chk("press_cnt_e6",   toggle_cnt, 1);
      step(1);
      chk("press_pulse_e7", pulse, 0);
      step(3);
      chk("press_one_pulse", pulse_cnt - p0, 1);
      chk("press_held_busy", busy, 1);
      // Release: idle at edge r+6.
      in = 1'b0;
      step(6);
      chk("rel_busy_r5", busy, 1);
      step(1);
      chk("rel_busy_r6", busy, 0);
      chk("rel_sel", sel_out, 1);

      // Short high burst is rejected.
      do_reset();
      p0 = pulse_cnt;
      in = 1'b1;
      step(3);
      in = 1'b0;
      step(6);
      chk("bounce_pulses", pulse_cnt - p0, 0);
      chk("bounce_sel",    sel_out, 0);
      chk("bounce_cnt",    toggle_cnt, 0);
      chk("bounce_busy",   busy, 0);

      // Bounce during release: low 2, high 1, then low.
      in = 1'b1;
      step(8);
      chk("rb_sel_acc", sel_out, 1);
      p0 = pulse_cnt;
      in = 1'b0;
      step(2);
      in = 1'b1;
      step(1);
      in = 1'b0;
      step(6);
      chk("rb_busy_r5", busy, 1);
      step(1);
      chk("rb_busy_r6", busy, 0);
      chk("rb_no_pulse", pulse_cnt - p0, 0);
      chk("rb_sel",      sel_out, 1);
      chk("rb_cnt",      toggle_cnt, 1);

      // 17 presses wrap the counter to 1.
      do_reset();
      p0 = pulse_cnt;
      for (int i = 0; i < 17; i++) press_release();
      chk("wrap_pulses", pulse_cnt - p0, 17);
      chk("wrap_cnt",    toggle_cnt, 1);
      chk("wrap_sel",    sel_out, 1);

      // Plain clear.
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("clr_sel",  sel_out, 0);
      chk("clr_cnt",  toggle_cnt, 0);
      chk("clr_busy", busy, 0);

      // Seed sel=1,cnt=1, then clear coinciding with the accepting edge.
      press_release();
      chk("pre_col_cnt", toggle_cnt, 1);
      in = 1'b1;
      step(6);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk("col_pulse", pulse, 1);
      chk("col_sel",   sel_out, 0);
      chk("col_cnt",   toggle_cnt, 0);
      in = 1'b0;
      step(8);

      // Reset while held with sel=1, button kept high afterwards.
      in = 1'b1;
      step(8);
      chk("mid_sel_pre",  sel_out, 1);
      chk("mid_busy_pre", busy, 1);
      rst = 1'b1;
      step(1);
      rst = 1'b0;
      chk("mid_rst_sel",   sel_out, 0);
      chk("mid_rst_pulse", pulse, 0);
      chk("mid_rst_cnt",   toggle_cnt, 0);
      chk("mid_rst_busy",  busy, 0);
      step(6);
      chk("mid_sel_e5", sel_out, 0);
      step(1);
      chk("mid_sel_e6",   sel_out, 1);
      chk("mid_pulse_e6", pulse, 1);
      chk("mid_cnt_e6",   toggle_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
